// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: command codes, ack byte
// and FSM state encoding.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'hBB;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    RF_WR,
    RF_RD,
    WAIT_RD,
    SEND,
    TX_HI,
    TX_LO
  } state_t;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes AA/BB frames into register-file writes and reads,
// returning read data over UART. Define WRITE_ACK_EN to answer every write with 0x5A.
module uart_cmd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_tx_busy,
  output logic [WIDTH-1:0]      o_tx_data,
  output logic                  o_tx_valid,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic                  o_rf_wr_en,
  output logic [WIDTH-1:0]      o_rf_wr_data,
  output logic                  o_rf_rd_en,
  input  logic [WIDTH-1:0]      i_rf_rd_data,
  input  logic                  i_rf_rd_valid,
  output logic                  o_err
);

  import uart_cmd_ctrl_pkg::*;

  localparam logic [WIDTH-1:0] LP_CMD_WR = WIDTH'(CMD_WRITE);
  localparam logic [WIDTH-1:0] LP_CMD_RD = WIDTH'(CMD_READ);
  localparam logic [WIDTH-1:0] LP_ACK    = WIDTH'(ACK_BYTE);

  state_t                r_state;
  state_t                w_next;
  logic [WIDTH-1:0]      r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_tx;
  logic                  r_tx_valid;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_err;

  logic w_err;
  logic w_tx_valid;
  logic w_cap_cmd;
  logic w_cap_addr;
  logic w_cap_data;
  logic w_cap_rd;
  logic w_cap_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err      = 1'b0;
    w_tx_valid = 1'b0;
    w_cap_cmd  = 1'b0;
    w_cap_addr = 1'b0;
    w_cap_data = 1'b0;
    w_cap_rd   = 1'b0;
    w_cap_ack  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == LP_CMD_WR || i_rx_data == LP_CMD_RD) begin
            w_cap_cmd = 1'b1;
            w_next    = GET_ADDR;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (i_rx_valid) begin
          w_cap_addr = 1'b1;
          w_next     = (r_cmd == LP_CMD_RD) ? RF_RD : GET_DATA;
        end
      end
      GET_DATA: begin
        if (i_rx_valid) begin
          w_cap_data = 1'b1;
          w_next     = RF_WR;
        end
      end
      RF_WR: begin
`ifdef WRITE_ACK_EN
        w_cap_ack = 1'b1;
        w_next    = SEND;
`else
        w_next    = IDLE;
`endif
      end
      // Read data may arrive in the same cycle as the strobe.
      RF_RD: begin
        if (i_rf_rd_valid) begin
          w_cap_rd = 1'b1;
          w_next   = SEND;
        end else begin
          w_next = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (i_rf_rd_valid) begin
          w_cap_rd = 1'b1;
          w_next   = SEND;
        end
      end
      SEND: begin
        if (!i_tx_busy) begin
          w_tx_valid = 1'b1;
          w_next     = TX_HI;
        end
      end
      TX_HI:   if (i_tx_busy)  w_next = TX_LO;
      TX_LO:   if (!i_tx_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered off the next state so each lasts exactly one state visit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_tx       <= '0;
      r_tx_valid <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= w_err;
      r_tx_valid <= w_tx_valid;
      r_wr_en    <= (w_next == RF_WR);
      r_rd_en    <= (w_next == RF_RD);
      if (w_cap_cmd)  r_cmd  <= i_rx_data;
      if (w_cap_addr) r_addr <= i_rx_data[ADDR_WIDTH-1:0];
      if (w_cap_data) r_data <= i_rx_data;
      if (w_cap_rd)       r_tx <= i_rf_rd_data;
      else if (w_cap_ack) r_tx <= LP_ACK;
    end
  end

  assign o_tx_data    = r_tx;
  assign o_tx_valid   = r_tx_valid;
  assign o_rf_addr    = r_addr;
  assign o_rf_wr_en   = r_wr_en;
  assign o_rf_wr_data = r_data;
  assign o_rf_rd_en   = r_rd_en;
  assign o_err        = r_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table of frames, hand-written corner
// sequences, then random frames against a transaction-level model.
module tb_uart_cmd_ctrl;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 4;

  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_TX  = 2;
  localparam int EV_ERR = 3;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic [WIDTH-1:0]      i_rx_data;
  logic                  i_rx_valid;
  logic                  i_tx_busy;
  logic [WIDTH-1:0]      o_tx_data;
  logic                  o_tx_valid;
  logic [ADDR_WIDTH-1:0] o_rf_addr;
  logic                  o_rf_wr_en;
  logic [WIDTH-1:0]      o_rf_wr_data;
  logic                  o_rf_rd_en;
  logic [WIDTH-1:0]      i_rf_rd_data;
  logic                  i_rf_rd_valid;
  logic                  o_err;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    int         expKind;
    logic [3:0] expAddr;
    logic [7:0] expData;
  } vec_t;

  ev_t        actQ[$];
  ev_t        expQ[$];
  vec_t       vecs[16];
  int         total = 0;
  int         bad = 0;
  int         cycleCnt = 0;
  logic [7:0] rfMem[16];
  logic [7:0] modelMem[16];
  int         rdDelay = 1;
  int         txLag = 0;
  int         busyLen = 3;
  logic       busyForce = 1'b0;
  logic       busyTx = 1'b0;
  int         byteCyc[3];

  assign i_tx_busy = busyForce | busyTx;

  uart_cmd_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_tx_busy    (i_tx_busy),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .o_rf_addr    (o_rf_addr),
    .o_rf_wr_en   (o_rf_wr_en),
    .o_rf_wr_data (o_rf_wr_data),
    .o_rf_rd_en   (o_rf_rd_en),
    .i_rf_rd_data (i_rf_rd_data),
    .i_rf_rd_valid(i_rf_rd_valid),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycleCnt++;

  // Register file stand-in: stores writes, answers reads after rdDelay cycles.
  always @(posedge i_clk) if (o_rf_wr_en) rfMem[o_rf_addr] <= o_rf_wr_data;

  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (o_rf_rd_en) begin
        for (int k = 0; k < rdDelay; k++) begin @(posedge i_clk); #1; end
        i_rf_rd_data  = rfMem[o_rf_addr];
        i_rf_rd_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rf_rd_valid = 1'b0;
        i_rf_rd_data  = 8'($urandom);
      end
    end
  end

  // Transmitter stand-in: raises busy txLag cycles after each send, for busyLen cycles.
  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (o_tx_valid) begin
        for (int k = 0; k < txLag; k++) begin @(posedge i_clk); #1; end
        busyTx = 1'b1;
        for (int k = 0; k < busyLen; k++) begin @(posedge i_clk); #1; end
        busyTx = 1'b0;
      end
    end
  end

  // Collect every strobe as a timestamped event and police mutual exclusion.
  always @(negedge i_clk) begin : monitor
    int hot;
    hot = int'(o_rf_wr_en) + int'(o_rf_rd_en) + int'(o_tx_valid) + int'(o_err);
    if (hot > 0) begin
      total++;
      if (hot > 1) begin
        bad++;
        $display("[TB] FAIL strobeExclusive: %0d strobes high at cycle %0d, required at most 1", hot, cycleCnt);
      end
    end
    if (o_rf_wr_en) actQ.push_back('{EV_WR, o_rf_addr, o_rf_wr_data, cycleCnt});
    if (o_rf_rd_en) actQ.push_back('{EV_RD, o_rf_addr, 8'h00, cycleCnt});
    if (o_tx_valid) actQ.push_back('{EV_TX, 4'h0, o_tx_data, cycleCnt});
    if (o_err)      actQ.push_back('{EV_ERR, 4'h0, 8'h00, cycleCnt});
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int kind, input logic [3:0] a, input logic [7:0] d, input int c);
    expQ.push_back('{kind, a, d, c});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic sendByte(input logic [7:0] b, output int cyc);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    cyc        = cycleCnt;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int n, input int maxGap);
    logic [7:0] bytes[3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && maxGap > 0) waitCycles($urandom_range(maxGap, 0));
      sendByte(bytes[i], byteCyc[i]);
    end
  endtask

  task automatic checkOutput(input string name);
    int m;
    bit ok;
    total++;
    if (actQ.size() != expQ.size()) begin
      bad++;
      $display("[TB] FAIL %s.count: got %0d events required %0d", name, actQ.size(), expQ.size());
    end
    m = (actQ.size() < expQ.size()) ? actQ.size() : expQ.size();
    for (int i = 0; i < m; i++) begin
      ok = (actQ[i].kind == expQ[i].kind) && (actQ[i].addr == expQ[i].addr) &&
           (actQ[i].data == expQ[i].data) && (expQ[i].cyc < 0 || actQ[i].cyc == expQ[i].cyc);
      total++;
      if (!ok) begin
        bad++;
        $display("[TB] FAIL %s.ev%0d: got kind=%0d addr=%0h data=%0h cyc=%0d required kind=%0d addr=%0h data=%0h cyc=%0d",
                 name, i, actQ[i].kind, actQ[i].addr, actQ[i].data, actQ[i].cyc,
                 expQ[i].kind, expQ[i].addr, expQ[i].data, expQ[i].cyc);
      end
    end
    actQ.delete();
    expQ.delete();
  endtask

  task automatic checkZero(input string name);
    checkVal({name, ".tx_valid"}, 32'(o_tx_valid), 0);
    checkVal({name, ".tx_data"},  32'(o_tx_data), 0);
    checkVal({name, ".rf_addr"},  32'(o_rf_addr), 0);
    checkVal({name, ".wr_en"},    32'(o_rf_wr_en), 0);
    checkVal({name, ".wr_data"},  32'(o_rf_wr_data), 0);
    checkVal({name, ".rd_en"},    32'(o_rf_rd_en), 0);
    checkVal({name, ".err"},      32'(o_err), 0);
  endtask

  task automatic expectAck();
`ifdef WRITE_ACK_EN
    pushExp(EV_TX, 4'h0, 8'h5A, -1);
`endif
  endtask

  // Frame-level model: a complete write stores and strobes one cycle after its last
  // byte, a read strobes one cycle after its address and returns stored data, any
  // other leading byte raises err one cycle later.
  task automatic modelFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    if (b0 == 8'hAA && n == 3) begin
      pushExp(EV_WR, b1[3:0], b2, byteCyc[2] + 1);
      expectAck();
      modelMem[b1[3:0]] = b2;
    end else if (b0 == 8'hBB && n >= 2) begin
      pushExp(EV_RD, b1[3:0], 8'h00, byteCyc[1] + 1);
      pushExp(EV_TX, 4'h0, modelMem[b1[3:0]], -1);
    end else if (n == 1) begin
      pushExp(EV_ERR, 4'h0, 8'h00, byteCyc[0] + 1);
    end
  endtask

  initial begin
    int releaseCyc;
    int w;
    int junkCyc;
    logic [7:0] b0, b1, b2;
    int sel;

    vecs[0]  = '{8'hAA, 8'h03, 8'h7E, 3, EV_WR,  4'h3, 8'h7E};
    vecs[1]  = '{8'hBB, 8'h03, 8'h00, 2, EV_RD,  4'h3, 8'h7E};
    vecs[2]  = '{8'h11, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00};
    vecs[3]  = '{8'hAA, 8'h01, 8'h02, 3, EV_WR,  4'h1, 8'h02};
    vecs[4]  = '{8'hBB, 8'h01, 8'h00, 2, EV_RD,  4'h1, 8'h02};
    vecs[5]  = '{8'hAA, 8'h0F, 8'hFF, 3, EV_WR,  4'hF, 8'hFF};
    vecs[6]  = '{8'hBB, 8'h0F, 8'h00, 2, EV_RD,  4'hF, 8'hFF};
    vecs[7]  = '{8'hAA, 8'hF5, 8'h00, 3, EV_WR,  4'h5, 8'h00};
    vecs[8]  = '{8'hBB, 8'h35, 8'h00, 2, EV_RD,  4'h5, 8'h00};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00};
    vecs[10] = '{8'hFF, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00};
    vecs[11] = '{8'hAB, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00};
    vecs[12] = '{8'hBB, 8'h07, 8'h00, 2, EV_RD,  4'h7, 8'h00};
    vecs[13] = '{8'hAA, 8'h00, 8'hA5, 3, EV_WR,  4'h0, 8'hA5};
    vecs[14] = '{8'hBB, 8'h80, 8'h00, 2, EV_RD,  4'h0, 8'hA5};
    vecs[15] = '{8'hBA, 8'h00, 8'h00, 1, EV_ERR, 4'h0, 8'h00};

    for (int i = 0; i < 16; i++) begin
      rfMem[i]    = 8'h00;
      modelMem[i] = 8'h00;
    end

    i_rst         = 1'b1;
    i_rx_valid    = 1'b0;
    i_rx_data     = 8'h00;
    i_rf_rd_valid = 1'b0;
    i_rf_rd_data  = 8'h00;
    #1;
    checkZero("reset");
    waitCycles(2);
    i_rst = 1'b0;
    waitCycles(2);

    $display("[TB] table vectors");
    for (int i = 0; i < 16; i++) begin
      rdDelay = i % 4;
      txLag   = i % 3;
      busyLen = 1 + i % 5;
      applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, i % 3);
      case (vecs[i].expKind)
        EV_WR: begin
          pushExp(EV_WR, vecs[i].expAddr, vecs[i].expData, byteCyc[2] + 1);
          expectAck();
          modelMem[vecs[i].expAddr] = vecs[i].expData;
        end
        EV_RD: begin
          pushExp(EV_RD, vecs[i].expAddr, 8'h00, byteCyc[1] + 1);
          pushExp(EV_TX, 4'h0, vecs[i].expData, -1);
        end
        default: pushExp(EV_ERR, 4'h0, 8'h00, byteCyc[0] + 1);
      endcase
      waitCycles(40);
      checkOutput($sformatf("vec%0d", i));
    end

    $display("[TB] read data two cycles after strobe");
    rdDelay = 2;
    txLag   = 1;
    busyLen = 4;
    applyStimulus(8'hAA, 8'h05, 8'hC3, 3, 0);
    pushExp(EV_WR, 4'h5, 8'hC3, byteCyc[2] + 1);
    expectAck();
    modelMem[5] = 8'hC3;
    waitCycles(40);
    checkOutput("wr05");
    applyStimulus(8'hBB, 8'h05, 8'h00, 2, 0);
    pushExp(EV_RD, 4'h5, 8'h00, byteCyc[1] + 1);
    pushExp(EV_TX, 4'h0, 8'hC3, -1);
    waitCycles(40);
    checkOutput("rd05");

    $display("[TB] transmitter busy at send, extra byte during transmit");
    busyForce = 1'b1;
    rdDelay   = 0;
    txLag     = 0;
    busyLen   = 6;
    applyStimulus(8'hBB, 8'h03, 8'h00, 2, 0);
    pushExp(EV_RD, 4'h3, 8'h00, byteCyc[1] + 1);
    pushExp(EV_TX, 4'h0, modelMem[3], -1);
    waitCycles(20);
    checkVal("busyHold.events", actQ.size(), 1);
    releaseCyc = cycleCnt;
    busyForce  = 1'b0;
    w = 0;
    while (actQ.size() < 2 && w < 50) begin
      waitCycles(1);
      w++;
    end
    checkVal("busyRelease.txSeen", 32'(actQ.size() >= 2), 1);
    if (actQ.size() >= 2) checkVal("busyRelease.txCycle", actQ[1].cyc, releaseCyc + 1);
    sendByte(8'h55, junkCyc);
    waitCycles(30);
    checkOutput("busyRead");

    $display("[TB] reset mid-frame");
    rdDelay = 1;
    busyLen = 3;
    applyStimulus(8'hAA, 8'h04, 8'h00, 2, 0);
    waitCycles(1);
    #2 i_rst = 1'b1;
    #1;
    checkZero("midFrameReset");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    waitCycles(2);
    checkOutput("partialFrame");
    applyStimulus(8'hBB, 8'h04, 8'h00, 2, 0);
    pushExp(EV_RD, 4'h4, 8'h00, byteCyc[1] + 1);
    pushExp(EV_TX, 4'h0, modelMem[4], -1);
    waitCycles(40);
    checkOutput("rdAfterReset");

    $display("[TB] reset mid-transmit");
    busyForce = 1'b1;
    applyStimulus(8'hBB, 8'h02, 8'h00, 2, 0);
    pushExp(EV_RD, 4'h2, 8'h00, byteCyc[1] + 1);
    waitCycles(8);
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst     = 1'b0;
    busyForce = 1'b0;
    waitCycles(20);
    checkOutput("txDiscarded");
    applyStimulus(8'hAA, 8'h02, 8'h3C, 3, 1);
    modelFrame(8'hAA, 8'h02, 8'h3C, 3);
    waitCycles(40);
    checkOutput("wrAfterTxReset");

    $display("[TB] random frames");
    for (int i = 0; i < 60; i++) begin
      rdDelay = $urandom_range(3, 0);
      txLag   = $urandom_range(2, 0);
      busyLen = $urandom_range(6, 1);
      sel     = $urandom_range(9, 0);
      b1      = 8'($urandom);
      b2      = 8'($urandom);
      if (sel < 4) begin
        b0 = 8'hAA;
        applyStimulus(b0, b1, b2, 3, 3);
        modelFrame(b0, b1, b2, 3);
      end else if (sel < 8) begin
        b0 = 8'hBB;
        applyStimulus(b0, b1, b2, 2, 3);
        modelFrame(b0, b1, b2, 2);
      end else begin
        b0 = 8'($urandom);
        while (b0 == 8'hAA || b0 == 8'hBB) b0 = 8'($urandom);
        applyStimulus(b0, b1, b2, 1, 0);
        modelFrame(b0, b1, b2, 1);
      end
      if (sel < 8 && $urandom_range(1, 0) == 1) sendByte(8'($urandom), junkCyc);
      waitCycles(40);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
